core_scheduler: RTL and testbench

Job scheduler that shares a pool of processing cores between the jobs of one run. It sits above the core array in `top`: it accepts a start command and a job count, issues job indices to idle cores over a start/done handshake, and tracks completions. It asserts `end_process` once every job has finished, which is the signal the top-level bench waits on before reading results.

---
 rtl/core_sched_pkg.sv | 23 ++
 rtl/core_scheduler_if.sv | 24 ++
 rtl/core_scheduler_prio_pick.sv | 17 +
 rtl/core_scheduler.sv | 116 +++++++++++
 tb/tb_core_scheduler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_sched_pkg.sv
// Shared constants for the core scheduler: state encoding, default sizing and
// a small popcount helper used to count simultaneous completions.
package core_sched_pkg;

   localparam int unsigned DEF_N_CORES = 4;
   localparam int unsigned DEF_JOB_W   = 12;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DISPATCH = 2'd1;
   localparam logic [1:0] WAIT     = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   // Scheduler supports at most 8 cores, so an 8-bit popcount covers every case.
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// Command and core handshake bundle between a run controller / core array
// (master side) and the core scheduler (slave side).
interface core_scheduler_if #(
   parameter int unsigned N_CORES = core_sched_pkg::DEF_N_CORES,
   parameter int unsigned JOB_W   = core_sched_pkg::DEF_JOB_W
);
   logic                       start;
   logic [JOB_W-1:0]           num_jobs;
   logic [N_CORES-1:0]         core_done;
   logic [N_CORES-1:0]         core_start;
   logic [N_CORES*JOB_W-1:0]   core_job_idx;
   logic                       busy;
   logic                       end_process;

   modport master (
      output start, num_jobs, core_done,
      input  core_start, core_job_idx, busy, end_process
   );

   modport slave (
      input  start, num_jobs, core_done,
      output core_start, core_job_idx, busy, end_process
   );
endinterface

// File: rtl/core_scheduler_prio_pick.sv
// Lowest-index-first selector over the free-core vector: one-hot grant plus a
// flag saying whether any core is free.
module prio_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] free_i,
   output logic [N-1:0] grant_o,
   output logic         valid_o
);

   always_comb begin
      // Two's-complement trick isolates the lowest set bit.
      grant_o = free_i & (~free_i + N'(1));
      valid_o = |free_i;
   end

endmodule

// File: rtl/core_scheduler.sv
// Dispatches job indices of one run to a pool of cores, one issue per cycle,
// and raises end_process once every issued job has reported completion.
module core_scheduler import core_sched_pkg::*; #(
   parameter int unsigned N_CORES = DEF_N_CORES,
   parameter int unsigned JOB_W   = DEF_JOB_W
) (
   input logic              clk,
   input logic              rst_n,
   core_scheduler_if.slave  bus
);

   localparam int unsigned CNT_W = JOB_W + 1;

   logic [1:0]               state_q, state_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [CNT_W-1:0]         next_job_q, next_job_d;
   logic [CNT_W-1:0]         done_cnt_q, done_cnt_d;
   logic [N_CORES-1:0]       free_q, free_d;
   logic [N_CORES-1:0]       core_start_q, core_start_d;
   logic [N_CORES*JOB_W-1:0] job_idx_q, job_idx_d;
   logic                     busy_q, busy_d;
   logic                     end_q, end_d;

   logic [N_CORES-1:0]       grant;
   logic                     pick_valid;
   logic [N_CORES-1:0]       done_valid;
   logic [7:0]               done_vec8;

   prio_pick #(
      .N (N_CORES)
   ) u_prio_pick (
      .free_i  (free_q),
      .grant_o (grant),
      .valid_o (pick_valid)
   );

   always_comb begin
      // Completions from cores that are not running a job are ignored.
      done_valid = bus.core_done & ~free_q;
      done_vec8  = 8'(done_valid);
      free_d     = free_q | done_valid;
      done_cnt_d = done_cnt_q + CNT_W'(popcount8(done_vec8));

      state_d      = state_q;
      count_d      = count_q;
      next_job_d   = next_job_q;
      core_start_d = '0;
      job_idx_d    = job_idx_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               count_d    = {1'b0, bus.num_jobs};
               next_job_d = '0;
               done_cnt_d = '0;
               state_d    = (bus.num_jobs == '0) ? DONE : DISPATCH;
            end
         end
         DISPATCH: begin
            // Grant is taken from free_q, so a core freed this edge waits a cycle.
            if ((next_job_q < count_q) && pick_valid) begin
               core_start_d = grant;
               free_d       = free_d & ~grant;
               next_job_d   = next_job_q + CNT_W'(1);
               for (int i = 0; i < N_CORES; i++) begin
                  if (grant[i]) begin
                     job_idx_d[i*JOB_W +: JOB_W] = next_job_q[JOB_W-1:0];
                  end
               end
            end
            if (next_job_d == count_q) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (done_cnt_d == count_q) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == DISPATCH) || (state_d == WAIT);
      end_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         count_q      <= '0;
         next_job_q   <= '0;
         done_cnt_q   <= '0;
         free_q       <= '1;
         core_start_q <= '0;
         job_idx_q    <= '0;
         busy_q       <= 1'b0;
         end_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         next_job_q   <= next_job_d;
         done_cnt_q   <= done_cnt_d;
         free_q       <= free_d;
         core_start_q <= core_start_d;
         job_idx_q    <= job_idx_d;
         busy_q       <= busy_d;
         end_q        <= end_d;
      end
   end

   assign bus.core_start   = core_start_q;
   assign bus.core_job_idx = job_idx_q;
   assign bus.busy         = busy_q;
   assign bus.end_process  = end_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: directed runs push expected core_start
// and end_process events; a negedge monitor pops and compares them.
module tb_core_scheduler;

   localparam int NC = 4;
   localparam int JW = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   core_scheduler_if #(.N_CORES(NC), .JOB_W(JW)) bus ();

   core_scheduler #(
      .N_CORES (NC),
      .JOB_W   (JW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [NC-1:0] vec;
      logic [JW-1:0] idx;
      int            edge_n;
   } start_ev_t;

   start_ev_t start_q[$];
   int        end_q[$];
   int        tests = 0;
   int        fails = 0;
   int        cyc = 0;
   logic      end_prev = 1'b0;
   start_ev_t mon_ev;
   int        mon_c;
   int        mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_start(input int core, input int idx, input int e);
      start_ev_t ev;
      ev.vec    = NC'(1) << core;
      ev.idx    = JW'(idx);
      ev.edge_n = e;
      start_q.push_back(ev);
   endtask

   task automatic do_start(input int n);
      bus.num_jobs = JW'(n);
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   task automatic pulse_done(input logic [NC-1:0] v);
      bus.core_done = v;
      tick();
      bus.core_done = '0;
   endtask

   // Monitor: every core_start pulse and every end_process rise must match the queue.
   always @(negedge clk) begin
      if (cyc >= 2) begin
         if (bus.core_start != '0) begin
            if (start_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_start: got vec %b at edge %0d, expected none",
                        bus.core_start, cyc);
            end else begin
               mon_ev = start_q.pop_front();
               mon_c  = 0;
               for (int i = NC - 1; i >= 0; i--) begin
                  if (bus.core_start[i]) mon_c = i;
               end
               check("start_vec", 32'(bus.core_start), 32'(mon_ev.vec));
               check("start_idx", 32'(bus.core_job_idx[mon_c*JW +: JW]), 32'(mon_ev.idx));
               check("start_edge", cyc, mon_ev.edge_n);
            end
         end
         if (bus.end_process && !end_prev) begin
            if (end_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_end: got end_process rise at edge %0d, expected none",
                        cyc);
            end else begin
               mon_e = end_q.pop_front();
               check("end_edge", cyc, mon_e);
            end
         end
         end_prev = bus.end_process;
      end
   end

   initial begin
      int e0;
      int ed;
      bus.start     = 1'b0;
      bus.num_jobs  = '0;
      bus.core_done = '0;
      rst_n         = 1'b0;
      repeat (3) tick();
      check("rst_core_start", 32'(bus.core_start), 0);
      check("rst_job_idx", bus.core_job_idx[31:0], 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_end", 32'(bus.end_process), 0);
      rst_n = 1'b1;
      tick();

      // Zero jobs from IDLE
      e0 = cyc + 1;
      end_q.push_back(e0);
      do_start(0);
      check("zero_busy", 32'(bus.busy), 0);
      check("zero_end", 32'(bus.end_process), 1);
      repeat (3) tick();

      // Single job
      e0 = cyc + 1;
      expect_start(0, 0, e0 + 1);
      do_start(1);
      check("single_end_fall", 32'(bus.end_process), 0);
      check("single_busy", 32'(bus.busy), 1);
      repeat (3) tick();
      ed = cyc + 1;
      end_q.push_back(ed);
      pulse_done(4'b0001);
      check("single_end", 32'(bus.end_process), 1);
      check("single_busy_low", 32'(bus.busy), 0);
      tick();

      // Fill then refill, plus simultaneous and spurious completions
      e0 = cyc + 1;
      for (int k = 0; k < 4; k++) expect_start(k, k, e0 + 1 + k);
      do_start(6);
      repeat (5) tick();
      check("fill_busy", 32'(bus.busy), 1);
      ed = cyc + 1;
      expect_start(2, 4, ed + 1);
      pulse_done(4'b0100);
      tick();
      check("idx_hold_core1", 32'(bus.core_job_idx[1*JW +: JW]), 1);
      ed = cyc + 1;
      expect_start(0, 5, ed + 1);
      pulse_done(4'b0001);
      tick();
      pulse_done(4'b1000);
      pulse_done(4'b1011);
      check("spurious_busy", 32'(bus.busy), 1);
      check("spurious_end", 32'(bus.end_process), 0);
      tick();
      ed = cyc + 1;
      end_q.push_back(ed);
      pulse_done(4'b0100);
      check("fill_end", 32'(bus.end_process), 1);
      repeat (2) tick();

      // Restart from DONE
      e0 = cyc + 1;
      for (int k = 0; k < 3; k++) expect_start(k, k, e0 + 1 + k);
      do_start(3);
      check("restart_end_fall", 32'(bus.end_process), 0);
      check("restart_busy", 32'(bus.busy), 1);
      repeat (4) tick();
      ed = cyc + 1;
      end_q.push_back(ed);
      pulse_done(4'b0111);
      check("restart_end", 32'(bus.end_process), 1);
      tick();

      // Reset mid-run
      e0 = cyc + 1;
      expect_start(0, 0, e0 + 1);
      expect_start(1, 1, e0 + 2);
      do_start(6);
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_core_start", 32'(bus.core_start), 0);
      check("midrst_job_idx", bus.core_job_idx[31:0], 0);
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_end", 32'(bus.end_process), 0);
      rst_n = 1'b1;
      bus.core_done = 4'b1111;
      repeat (2) tick();
      bus.core_done = '0;
      check("post_rst_busy", 32'(bus.busy), 0);
      check("post_rst_end", 32'(bus.end_process), 0);
      e0 = cyc + 1;
      expect_start(0, 0, e0 + 1);
      do_start(1);
      repeat (2) tick();
      ed = cyc + 1;
      end_q.push_back(ed);
      pulse_done(4'b0001);
      check("post_rst_done", 32'(bus.end_process), 1);

      repeat (3) tick();
      check("start_q_drained", start_q.size(), 0);
      check("end_q_drained", end_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
